// File: rtl/snn_pkg.sv
// Shared SNN types and helpers: AER drop counter width, encoder state, priority encoder.
// Latency: n/a (declarations and a combinational function only).
// Backpressure: n/a.
package snn_pkg;

  localparam int AER_DROP_CNT_W = 8;

  // Widest spike vector the priority encoder handles; callers zero-extend.
  localparam int AER_MAX_N = 256;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } aer_state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int lowest_set_index(input logic [AER_MAX_N-1:0] v);
    int idx;
    idx = 0;
    // Scan downward so the lowest set bit is the one that sticks.
    for (int i = AER_MAX_N - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/spike_frame_fifo.sv
// Synchronous frame FIFO with first-word fall-through output.
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; callers gate on full/empty.
module spike_frame_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Read/write pointer advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Captures one spike vector per tick and serializes set bits into an AER stream, lowest index first.
// Latency: tick in cycle k (idle, empty) gives first aer_valid in cycle k+2; one event per cycle after that.
// Backpressure: aer_valid/aer_ready; frames buffer in a DEPTH-frame FIFO, overflow drops are flagged and counted.
// Build option SNN_AER_TIMESTAMP_EN: enables the timestep counter and per-frame timestamps; otherwise aer_ts is 0.
module spike_aer_encoder
  import snn_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0]              spike_in,
  input  logic                      tick,
  output logic                      aer_valid,
  input  logic                      aer_ready,
  output logic [$clog2(N)-1:0]      aer_addr,
  output logic [TS_W-1:0]           aer_ts,
  output logic                      aer_last,
  output logic                      overflow,
  output logic [AER_DROP_CNT_W-1:0] drop_count,
  output logic                      busy
);

  localparam int AW = $clog2(N);
  localparam logic [N-1:0] BITS_ONE = 1;
  localparam logic [AER_DROP_CNT_W-1:0] DROP_ONE = 1;

`ifdef SNN_AER_TIMESTAMP_EN
  localparam int FW = N + TS_W;
`else
  localparam int FW = N;
`endif

  aer_state_t           state;
  aer_state_t           state_next;
  logic [N-1:0]         bits;
  logic [N-1:0]         bits_next;
  logic [AER_MAX_N-1:0] bits_next_ext;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [FW-1:0]        fifo_din;
  logic [FW-1:0]        fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [N-1:0]         frame_bits;
  logic                 frame_nonzero;
  logic                 drop;
  logic                 handshake;

  // Fullness is judged before any same-cycle pop, so a push into a full FIFO drops.
  assign frame_nonzero = |spike_in;
  assign fifo_push     = tick & frame_nonzero & ~fifo_full;
  assign drop          = tick & frame_nonzero & fifo_full;
  assign handshake     = aer_valid & aer_ready;
  assign busy          = ~fifo_empty | (state == EMIT);

`ifdef SNN_AER_TIMESTAMP_EN
  localparam logic [TS_W-1:0] TS_ONE = 1;
  logic [TS_W-1:0] ts_cnt;

  assign fifo_din   = {spike_in, ts_cnt};
  assign frame_bits = fifo_dout[FW-1:TS_W];

  // Timestep counter advances on every tick, empty frame or not.
  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= '0;
    else if (tick) ts_cnt <= ts_cnt + TS_ONE;
  end

  // The output timestamp is the work register's ts, loaded with each frame.
  always_ff @(posedge clk) begin
    if (reset) aer_ts <= '0;
    else if (fifo_pop) aer_ts <= fifo_dout[TS_W-1:0];
  end
`else
  assign fifo_din   = spike_in;
  assign frame_bits = fifo_dout;
  assign aer_ts     = '0;
`endif

  spike_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State and work-register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bits  <= '0;
    end else begin
      state <= state_next;
      bits  <= bits_next;
    end
  end

  // Next state: load a frame when idle, retire one bit per handshake, chain frames without a bubble.
  always_comb begin
    state_next = state;
    bits_next  = bits;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          bits_next  = frame_bits;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (handshake) begin
          if (!aer_last) begin
            bits_next = bits & (bits - BITS_ONE);
          end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            bits_next = frame_bits;
          end else begin
            bits_next  = '0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        bits_next  = '0;
      end
    endcase
  end

  // Zero-extend the next work bits to the priority encoder's fixed width.
  always_comb begin
    bits_next_ext          = '0;
    bits_next_ext[N-1:0]   = bits_next;
  end

  // Registered event outputs, precomputed from the next work register so they hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      aer_valid <= 1'b0;
      aer_addr  <= '0;
      aer_last  <= 1'b0;
    end else begin
      aer_valid <= (state_next == EMIT);
      aer_addr  <= AW'(lowest_set_index(bits_next_ext));
      aer_last  <= (state_next == EMIT) && ((bits_next & (bits_next - BITS_ONE)) == '0);
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_ONE;
    end
  end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Randomized and directed bench for spike_aer_encoder against a queue-based frame/event model.
// Latency: model predicts outputs for every cycle, compared on the falling edge.
// Backpressure: aer_ready is driven from directed patterns and randomly.
module tb_spike_aer_encoder;

  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int TS_W  = 8;
  localparam int AW    = $clog2(N);

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    spike_in;
  logic            tick;
  logic            aer_valid;
  logic            aer_ready;
  logic [AW-1:0]   aer_addr;
  logic [TS_W-1:0] aer_ts;
  logic            aer_last;
  logic            overflow;
  logic [7:0]      drop_count;
  logic            busy;

  always #5 clk = ~clk;

  spike_aer_encoder #(.N(N), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .tick       (tick),
    .aer_valid  (aer_valid),
    .aer_ready  (aer_ready),
    .aer_addr   (aer_addr),
    .aer_ts     (aer_ts),
    .aer_last   (aer_last),
    .overflow   (overflow),
    .drop_count (drop_count),
    .busy       (busy)
  );

  typedef struct { int addr; int ts; } ev_t;
  typedef struct { logic [N-1:0] bits; int ts; } fr_t;

  ev_t cur_q[$];
  fr_t fifo_q[$];
  int  m_ts;
  int  m_drops;
  bit  m_ovf;
  int  vectors;
  int  miscompares;
  int  hs_count;
  int  last_seen_ts;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ts_of(input int t);
`ifdef SNN_AER_TIMESTAMP_EN
    return t;
`else
    return 0;
`endif
  endfunction

  task automatic load_frame();
    fr_t f;
    ev_t e;
    f = fifo_q.pop_front();
    for (int i = 0; i < N; i++) begin
      if (f.bits[i]) begin
        e.addr = i;
        e.ts   = f.ts;
        cur_q.push_back(e);
      end
    end
  endtask

  // Frame-level model: whole frames queue up, each frame expands to a list of events.
  task automatic model_step();
    bit  emitting;
    bit  full_before;
    bit  empty_before;
    fr_t f;
    if (reset) begin
      cur_q.delete();
      fifo_q.delete();
      m_ts = 0; m_drops = 0; m_ovf = 0;
      return;
    end
    emitting     = (cur_q.size() > 0);
    full_before  = (fifo_q.size() == DEPTH);
    empty_before = (fifo_q.size() == 0);
    if (!emitting) begin
      if (!empty_before) load_frame();
    end else if (aer_ready) begin
      void'(cur_q.pop_front());
      if (cur_q.size() == 0 && !empty_before) load_frame();
    end
    if (tick) begin
      if (spike_in != '0) begin
        if (full_before) begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end else begin
          f.bits = spike_in;
          f.ts   = ts_of(m_ts);
          fifo_q.push_back(f);
        end
      end
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
  endtask

  task automatic check_outputs();
    bit mv;
    mv = (cur_q.size() > 0);
    check("valid", 64'(aer_valid), 64'(mv));
    check("busy", 64'(busy), 64'(mv || fifo_q.size() > 0));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("drop_count", 64'(drop_count), 64'(m_drops));
    if (mv) begin
      check("addr", 64'(aer_addr), 64'(cur_q[0].addr));
      check("ts", 64'(aer_ts), 64'(cur_q[0].ts));
      check("last", 64'(aer_last), 64'(cur_q.size() == 1));
    end
  endtask

  task automatic step(input bit t, input logic [N-1:0] s, input bit r, input bit rst);
    tick = t; spike_in = s; aer_ready = r; reset = rst;
    @(posedge clk);
    if (aer_valid && aer_ready && !reset) begin
      hs_count++;
      last_seen_ts = int'(aer_ts);
    end
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    vectors = 0; miscompares = 0; hs_count = 0; last_seen_ts = -1;
    m_ts = 0; m_drops = 0; m_ovf = 0;
    tick = 0; spike_in = '0; aer_ready = 0; reset = 1;

    // Reset state
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    check("rst_addr", 64'(aer_addr), 64'd0);
    check("rst_ts", 64'(aer_ts), 64'd0);
    check("rst_last", 64'(aer_last), 64'd0);

    // Empty frame then 0x8421; first valid two cycles after the tick
    step(1, 16'h0000, 1, 0);
    step(1, 16'h8421, 1, 0);
    check("lat_k1", 64'(aer_valid), 64'd0);
    step(0, '0, 1, 0);
    check("lat_k2", 64'(aer_valid), 64'd1);
    check("lat_ts", 64'(aer_ts), 64'(ts_of(1)));
    for (int i = 0; i < 6; i++) step(0, '0, 1, 0);

    // Stall with a two-event frame held for 10 cycles
    step(1, 16'h0003, 0, 0);
    for (int i = 0; i < 11; i++) step(0, '0, 0, 0);
    check("stall_addr", 64'(aer_addr), 64'd0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

    // Overflow: one frame in the work register plus DEPTH buffered, the next is dropped
    for (int i = 0; i < DEPTH + 2; i++) step(1, 16'h0001, 0, 0);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drops", 64'(drop_count), 64'd1);
    hs_count = 0;
    for (int i = 0; i < 12; i++) step(0, '0, 1, 0);
    check("ovf_events", 64'(hs_count), 64'(DEPTH + 1));

    // Back-to-back single-bit frames without a bubble
    step(1, 16'h0001, 1, 0);
    step(1, 16'h0002, 1, 0);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0);

    // Reset in the middle of a frame after three events
    step(1, 16'h00FF, 1, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    step(0, '0, 1, 1);
    check("mid_rst_valid", 64'(aer_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    step(1, 16'h0001, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    check("post_rst_ts", 64'(aer_ts), 64'd0);

    // Timestamp wrap: 2^TS_W + 1 ticks, final event carries ts 0
    step(0, '0, 1, 1);
    for (int i = 0; i < (1 << TS_W) + 1; i++) step(1, 16'h0001, 1, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    check("wrap_ts", 64'(last_seen_ts), 64'd0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] s;
      s = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 4) == 0) s = '0;
      step($urandom_range(0, 2) == 0, s, $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);
    end
    for (int i = 0; i < 80; i++) step(0, '0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
